watchdog_timer_ctrl: RTL and testbench

//   Supervisory watchdog for the AM radio FPGA datapath/control logic.
//   It counts clock cycles while armed and restarts on each heartbeat pulse from the supervised logic.
//   It raises an early warning, then a sticky timeout trip that downstream logic uses to reset or disable the radio.

---
 rtl/watchdog_timer_ctrl.sv | 53 +++++
 tb/tb_watchdog_timer_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/watchdog_timer_ctrl.sv
// Supervisory watchdog: counts armed cycles, restarts on heartbeat, raises warning
// and then a sticky trip that only disarming or reset can clear.
module watchdog_timer_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned WARN_CYCLES    = 750,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             heartbeat,
  input  logic             force_reset,
  output logic             warning,
  output logic             triggered,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WARN_VAL    = CNT_W'(WARN_CYCLES);

  logic [CNT_W-1:0] count_next;

  // Count freezes on trip, so this increment can never wrap.
  assign count_next = count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      warning   <= 1'b0;
      triggered <= 1'b0;
    end else if (!enable) begin
      count     <= '0;
      warning   <= 1'b0;
      triggered <= 1'b0;
    end else if (force_reset) begin
      warning   <= 1'b1;
      triggered <= 1'b1;
    end else if (triggered) begin
      // sticky: heartbeat is ignored and all outputs hold
      count     <= count;
      warning   <= warning;
      triggered <= triggered;
    end else if (heartbeat) begin
      count     <= '0;
      warning   <= 1'b0;
    end else begin
      count     <= count_next;
      warning   <= (count_next >= WARN_VAL);
      triggered <= (count_next >= TIMEOUT_VAL);
    end
  end

endmodule

// File: tb/tb_watchdog_timer_ctrl.sv
// Directed bench for watchdog_timer_ctrl with a per-cycle reference model
// plus hand-computed literal checks.
module tb_watchdog_timer_ctrl;
  localparam int T = 10;
  localparam int W = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        heartbeat = 1'b0;
  logic        force_reset = 1'b0;
  logic        warning;
  logic        triggered;
  logic [31:0] count;

  int total = 0;
  int bad = 0;

  // model state: cycles since last restart and whether the trip latched
  int m_cnt = 0;
  bit m_trip = 0;
  bit m_valid = 0;

  watchdog_timer_ctrl #(.TIMEOUT_CYCLES(T), .WARN_CYCLES(W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .heartbeat(heartbeat),
    .force_reset(force_reset), .warning(warning), .triggered(triggered), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_trip = 0; m_valid = 1;
    end else if (!enable) begin
      m_cnt = 0; m_trip = 0;
    end else if (force_reset) begin
      m_trip = 1;
    end else if (m_trip) begin
      // hold
    end else if (heartbeat) begin
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
      if (m_cnt >= T) m_trip = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // warning is the trip flag or the count having reached the warning level
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_count", count, m_cnt);
      chk("model_warning", {31'd0, warning}, {31'd0, (m_trip || m_cnt >= W)});
      chk("model_triggered", {31'd0, triggered}, {31'd0, m_trip});
    end
  end

  task automatic step(input logic r, input logic e, input logic h, input logic f);
    rst = r; enable = e; heartbeat = h; force_reset = f;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string tag, input int c, input bit w, input bit t);
    chk({tag, "_count"}, count, c);
    chk({tag, "_warning"}, {31'd0, warning}, {31'd0, w});
    chk({tag, "_triggered"}, {31'd0, triggered}, {31'd0, t});
  endtask

  int peak;
  bit seen_flag;

  initial begin
    // reset state
    step(1, 0, 0, 0);
    lit("reset", 0, 0, 0);

    // free run to timeout
    step(0, 1, 0, 0); lit("run1", 1, 0, 0);
    for (int i = 2; i <= 5; i++) step(0, 1, 0, 0);
    lit("run5", 5, 0, 0);
    step(0, 1, 0, 0); lit("run6_warn", 6, 1, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 1, 0, 0); lit("run9", 9, 1, 0);
    step(0, 1, 0, 0); lit("run10_trip", 10, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    lit("hold", 10, 1, 1);
    step(0, 1, 1, 0); lit("hb_ignored", 10, 1, 1);

    // disarm clears trip, rearm restarts from 1
    step(0, 0, 0, 0); lit("disarm", 0, 0, 0);
    step(0, 1, 0, 0); lit("rearm", 1, 0, 0);

    // periodic heartbeat
    step(0, 0, 0, 0);
    peak = 0; seen_flag = 0;
    for (int i = 0; i < 50; i++) begin
      step(0, 1, (i % 6 == 5), 0);
      if (count > peak) peak = count;
      if (warning || triggered) seen_flag = 1;
    end
    chk("hb_peak", peak, 5);
    chk("hb_no_flags", {31'd0, seen_flag}, 0);

    // manual trip at count 2
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0); lit("pre_force", 2, 0, 0);
    step(0, 1, 0, 1); lit("force", 2, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
    lit("force_sticky", 2, 1, 1);
    step(0, 0, 0, 1); lit("disarm_over_force", 0, 0, 0);

    // force beats heartbeat on the same edge
    step(0, 1, 1, 1); lit("force_over_hb", 0, 1, 1);

    // heartbeat on the edge that would time out
    step(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0);
    lit("pre_hb9", 9, 1, 0);
    step(0, 1, 1, 0); lit("hb_beats_timeout", 0, 0, 0);
    step(0, 1, 0, 0); lit("after_hb", 1, 0, 0);

    // reset mid-count beats force
    step(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    lit("pre_rst", 7, 1, 0);
    step(1, 1, 0, 1); lit("rst_over_force", 0, 0, 0);
    step(0, 1, 0, 0); lit("post_rst", 1, 0, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_bench_timeout: got stuck expected finish");
    $fatal(1);
  end
endmodule
